// File: rtl/imem_loader.sv
// Writable instruction memory: zero-sweep after reset, 1-cycle fetch port,
// and a byte-serial loader that assembles MSB-first words at run time.
module imem_loader #(
  parameter int    ADDR_W         = 31,
  parameter int    DATA_W         = 32,
  parameter int    DEPTH          = 256,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_ready,
  output logic                       fetch_valid,
  output logic [DATA_W-1:0]          fetch_data,
  output logic                       fetch_err,
  input  logic                       load_en,
  input  logic                       load_byte_valid,
  input  logic [7:0]                 load_byte,
  output logic [$clog2(DEPTH):0]     load_count,
  output logic                       load_ovf,
  output logic                       busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int BPW = DATA_W / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_RESET = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [AW:0]       load_ptr_q, load_ptr_d;
  logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              load_ovf_q, load_ovf_d;
  logic              fetch_valid_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_err_q;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              fetch_acc;
  logic              in_range;
  logic [AW-1:0]     fetch_idx;
  logic [DATA_W-1:0] word_asm;
  logic              last_byte;
  logic              mem_full;

  assign fetch_acc = (state_q == S_RUN) && fetch_req;
  assign in_range  = fetch_addr < ADDR_W'(DEPTH * 4);
  assign fetch_idx = fetch_addr[AW+1:2];
  // Shifting left keeps the first byte of a word in the top lane.
  assign word_asm  = (asm_q << 8) | DATA_W'(load_byte);
  assign last_byte = byte_cnt_q == BW'(BPW - 1);
  assign mem_full  = load_ptr_q == (AW+1)'(DEPTH);

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    load_ptr_d = load_ptr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    load_ovf_d = load_ovf_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_ptr_q;
    mem_wdata  = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == AW'(DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (load_en) begin
          state_d    = S_LOAD;
          load_ptr_d = '0;
          byte_cnt_d = '0;
          load_ovf_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_byte_valid) begin
          if (mem_full) begin
            load_ovf_d = 1'b1;
          end else begin
            asm_d = word_asm;
            if (last_byte) begin
              mem_we     = 1'b1;
              mem_waddr  = load_ptr_q[AW-1:0];
              mem_wdata  = word_asm;
              load_ptr_d = load_ptr_q + 1'b1;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
        // Leaving LOAD drops any partially assembled word.
        if (!load_en) begin
          state_d    = S_RUN;
          byte_cnt_d = '0;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_RESET;
      clr_ptr_q     <= '0;
      load_ptr_q    <= '0;
      byte_cnt_q    <= '0;
      load_ovf_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      load_ptr_q    <= load_ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      load_ovf_q    <= load_ovf_d;
      fetch_valid_q <= fetch_acc;
      if (fetch_acc) begin
        fetch_err_q  <= !in_range;
        fetch_data_q <= in_range ? mem[fetch_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    asm_q <= asm_d;
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign fetch_ready = state_q == S_RUN;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_err   = fetch_err_q;
  // Words written so far equals the write pointer, so one register serves both.
  assign load_count  = load_ptr_q;
  assign load_ovf    = load_ovf_q;
  assign busy        = state_q != S_RUN;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a 256-word and a 4-word instance share all inputs and
// are checked against array-based memory images with randomized loads/fetches.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic [30:0] fetch_addr = '0;
  logic        load_en = 1'b0;
  logic        load_byte_valid = 1'b0;
  logic [7:0]  load_byte = '0;

  logic        ready_a, valid_a, err_a, ovf_a, busy_a;
  logic [31:0] data_a;
  logic [8:0]  cnt_a;
  logic        ready_b, valid_b, err_b, ovf_b, busy_b;
  logic [31:0] data_b;
  logic [2:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ma [256];
  logic [31:0] mb [4];
  int          ecnt_a, ecnt_b;
  bit          eovf_a, eovf_b;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(256)) u_a (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(ready_a), .fetch_valid(valid_a), .fetch_data(data_a), .fetch_err(err_a),
    .load_en(load_en), .load_byte_valid(load_byte_valid), .load_byte(load_byte),
    .load_count(cnt_a), .load_ovf(ovf_a), .busy(busy_a)
  );

  imem_loader #(.DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(ready_b), .fetch_valid(valid_b), .fetch_data(data_b), .fetch_err(err_b),
    .load_en(load_en), .load_byte_valid(load_byte_valid), .load_byte(load_byte),
    .load_count(cnt_b), .load_ovf(ovf_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_a(input logic [30:0] a);
    return (a < 31'd1024) ? ma[a[9:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_b(input logic [30:0] a);
    return (a < 31'd16) ? mb[a[3:2]] : 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) ma[i] = '0;
    for (int i = 0; i < 4; i++) mb[i] = '0;
    ecnt_a = 0; ecnt_b = 0; eovf_a = 0; eovf_b = 0;
  endtask

  // A load session keeps only whole words, truncated to the memory size.
  task automatic model_load(input logic [7:0] q[$]);
    int words;
    logic [31:0] w;
    words = q.size() / 4;
    for (int i = 0; i < words; i++) begin
      w = {q[4*i], q[4*i+1], q[4*i+2], q[4*i+3]};
      if (i < 256) ma[i] = w;
      if (i < 4) mb[i] = w;
    end
    ecnt_a = (words > 256) ? 256 : words;
    ecnt_b = (words > 4) ? 4 : words;
    eovf_a = q.size() > 1024;
    eovf_b = q.size() > 16;
  endtask

  task automatic check_fetch(input logic [30:0] a);
    check("valid_a", valid_a, 1);
    check("data_a", data_a, exp_a(a));
    check("err_a", err_a, a >= 31'd1024);
    check("valid_b", valid_b, 1);
    check("data_b", data_b, exp_b(a));
    check("err_b", err_b, a >= 31'd16);
  endtask

  task automatic fetch_seq(input logic [30:0] addrs[$]);
    foreach (addrs[i]) begin
      fetch_req  = 1'b1;
      fetch_addr = addrs[i];
      tick();
      check_fetch(addrs[i]);
    end
    fetch_req = 1'b0;
    tick();
    check("valid_idle_a", valid_a, 0);
    check("valid_idle_b", valid_b, 0);
  endtask

  task automatic reset_sweep();
    int ca, cb;
    bit ready_seen;
    #3 reset = 1'b0;
    #1;
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_err", err_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_busy", busy_a, 1);
    check("rst_ready", ready_a, 0);
    load_en = 1'b0; load_byte_valid = 1'b0; fetch_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_clear();
    ca = 0; cb = 0; ready_seen = 0;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (ready_a && busy_a) ready_seen = 1;
      if (!busy_b && cb == 0) cb = i;
      if (!busy_a) begin
        ca = i;
        break;
      end
    end
    check("sweep_len_a", ca, 256);
    check("sweep_len_b", cb, 4);
    check("ready_in_clear", ready_seen, 0);
    check("ready_after", ready_a, 1);
  endtask

  task automatic do_load(input logic [7:0] q[$], input bit fall_with_last,
                         input bit fetch_at_entry, input logic [30:0] faddr);
    bit valid_seen;
    valid_seen = 0;
    load_en = 1'b1;
    if (fetch_at_entry) begin
      fetch_req  = 1'b1;
      fetch_addr = faddr;
    end
    tick();
    if (fetch_at_entry) begin
      fetch_req = 1'b0;
      check_fetch(faddr);
    end
    check("load_busy", busy_a, 1);
    check("load_ready", ready_a, 0);
    foreach (q[i]) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        load_byte_valid = 1'b0;
        tick();
        valid_seen |= valid_a;
      end
      load_byte_valid = 1'b1;
      load_byte       = q[i];
      if (i == q.size() - 1 && fall_with_last) load_en = 1'b0;
      tick();
      valid_seen |= valid_a;
    end
    load_byte_valid = 1'b0;
    load_en = 1'b0;
    tick();
    model_load(q);
    check("valid_in_load", valid_seen, 0);
    check("cnt_a", cnt_a, ecnt_a);
    check("ovf_a", ovf_a, eovf_a);
    check("cnt_b", cnt_b, ecnt_b);
    check("ovf_b", ovf_b, eovf_b);
    check("busy_after_load", busy_a, 0);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [30:0] aq[$];

    reset_sweep();
    fetch_seq('{31'h3FC});

    do_load('{8'h3C, 8'h10, 8'h40, 8'h00, 8'h20, 8'h14, 8'hEC, 8'h77}, 0, 0, 0);
    check("prog_cnt", cnt_a, 2);
    fetch_seq('{31'h0, 31'h4, 31'h6});
    fetch_seq('{31'h0, 31'h4, 31'h400});

    // Partial word, with a fetch accepted in the cycle load_en rises.
    do_load('{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6}, 1, 1, 31'h0);
    check("partial_cnt", cnt_a, 1);
    fetch_seq('{31'h0, 31'h4});
    check("word1_kept", data_a, 32'h2014EC77);

    q = {};
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    do_load(q, 0, 0, 0);
    check("ovf_b_set", ovf_b, 1);
    fetch_seq('{31'h0, 31'h4, 31'h8, 31'hC, 31'h10, 31'h14});

    for (int it = 0; it < 8; it++) begin
      q = {};
      for (int i = $urandom_range(0, 40); i > 0; i--) q.push_back(8'($urandom));
      do_load(q, 1'($urandom), 1'($urandom), 31'($urandom_range(0, 'h4FF)));
      aq = {};
      for (int i = 0; i < 6; i++)
        aq.push_back($urandom_range(0, 1) ? 31'($urandom_range(0, 31)) : 31'($urandom_range(0, 'h4FF)));
      fetch_seq(aq);
    end

    // Reset in the middle of a load, five bytes in.
    load_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      load_byte_valid = 1'b1;
      load_byte = 8'($urandom_range(1, 255));
      tick();
    end
    load_byte_valid = 1'b0;
    check("pre_reset_cnt", cnt_a, 1);
    reset_sweep();
    fetch_seq('{31'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
